// File: rtl/bsort_pkg.sv
// Shared defaults, FSM state type and pass-span constant for the bubble-sort pass engine.
package bsort_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned IDX_W_DEF  = 4;
    localparam int unsigned DEPTH_DEF  = 16;

    // A pass needs at least one pair, so ub must exceed lb by this much.
    localparam int unsigned MIN_SPAN = 1;

    typedef enum logic [1:0] {
        StIdle,
        StCmp,
        StDone
    } state_t;

endpackage

// File: rtl/bsort_cmp_swap.sv
// Combinational compare-swap of one adjacent pair; BSORT_DESC_EN selects descending order.
module bsort_cmp_swap
    import bsort_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] lo,
    output logic [DATA_W-1:0] hi,
    output logic              swap
);

    always_comb begin
`ifdef BSORT_DESC_EN
        swap = a < b;
`else
        swap = a > b;
`endif
        // lo lands at the lower index, hi at the higher one
        lo = swap ? b : a;
        hi = swap ? a : b;
    end

endmodule

// File: rtl/bsort_pass.sv
// One bubble-sort inner pass over an owned array: sweeps j from lb to ub-1, swapping out-of-order
// neighbours. Build with BSORT_DESC_EN for descending order.
module bsort_pass
    import bsort_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned IDX_W  = IDX_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_en,
    input  logic [IDX_W-1:0]  ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              start,
    input  logic [IDX_W-1:0]  lb,
    input  logic [IDX_W-1:0]  ub,
    input  logic [IDX_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              swapped,
    output logic [IDX_W-1:0]  j
);

    localparam logic [IDX_W:0] LAST_IDX = (IDX_W + 1)'(DEPTH - 1);
    localparam logic [IDX_W:0] SPAN     = (IDX_W + 1)'(MIN_SPAN);

    state_t state_q, state_d;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0]  ub_q;
    logic [IDX_W:0]    ub_clamp;
    logic [IDX_W:0]    j_nxt;
    logic              empty;
    logic              last_pair;
    logic              ld_ok;
    logic [DATA_W-1:0] cmp_a, cmp_b, cmp_lo, cmp_hi;
    logic              cmp_swap;

    always_comb begin
        ub_clamp  = ({1'b0, ub} > LAST_IDX) ? LAST_IDX : {1'b0, ub};
        empty     = ({1'b0, lb} + SPAN) > ub_clamp;
        // Extra bit keeps j+1 from wrapping at the top of the index range.
        j_nxt     = {1'b0, j} + (IDX_W + 1)'(1);
        last_pair = j_nxt == {1'b0, ub_q};
        ld_ok     = {1'b0, ld_addr} <= LAST_IDX;
        cmp_a     = mem[j];
        cmp_b     = mem[j_nxt[IDX_W-1:0]];
        rd_data   = ({1'b0, rd_addr} <= LAST_IDX) ? mem[rd_addr] : '0;
        busy      = state_q == StCmp;
        done      = state_q == StDone;
    end

    bsort_cmp_swap #(
        .DATA_W (DATA_W)
    ) u_cmp_swap (
        .a    (cmp_a),
        .b    (cmp_b),
        .lo   (cmp_lo),
        .hi   (cmp_hi),
        .swap (cmp_swap)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = empty ? StDone : StCmp;
            StCmp:   if (last_pair) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem     <= '{default: '0};
            j       <= '0;
            ub_q    <= '0;
            swapped <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (ld_en && ld_ok) mem[ld_addr] <= ld_data;
                    if (start) begin
                        swapped <= 1'b0;
                        if (!empty) begin
                            j    <= lb;
                            ub_q <= ub_clamp[IDX_W-1:0];
                        end
                    end
                end
                StCmp: begin
                    if (cmp_swap) begin
                        mem[j]                  <= cmp_lo;
                        mem[j_nxt[IDX_W-1:0]]   <= cmp_hi;
                        swapped                 <= 1'b1;
                    end
                    if (!last_pair) j <= j_nxt[IDX_W-1:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bsort_pass.sv
// Directed bench for bsort_pass: reset state, table of passes, mid-pass ignore and abort.
module tb_bsort_pass;

    logic       clk = 1'b0;
    logic       rst, ld_en, start, busy, done, swapped;
    logic [3:0] ld_addr, lb, ub, rd_addr, j;
    logic [7:0] ld_data, rd_data;

    always #5 clk = ~clk;

    bsort_pass #(
        .DATA_W (8),
        .IDX_W  (4),
        .DEPTH  (16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ld_en   (ld_en),
        .ld_addr (ld_addr),
        .ld_data (ld_data),
        .start   (start),
        .lb      (lb),
        .ub      (ub),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .busy    (busy),
        .done    (done),
        .swapped (swapped),
        .j       (j)
    );

    typedef struct packed {
        logic [3:0][7:0] din;
        logic [3:0]      lb;
        logic [3:0]      ub;
        logic [3:0][7:0] dout;
        logic            sw;
        logic [3:0]      cyc;
    } vec_t;

    vec_t vecs[6];
    int   checks = 0;
    int   errors = 0;

`ifdef BSORT_DESC_EN
    localparam logic [7:0] MID_RD0 = 8'd9;
    localparam logic [7:0] MID_RD1 = 8'd7;
`else
    localparam logic [7:0] MID_RD0 = 8'd7;
    localparam logic [7:0] MID_RD1 = 8'd6;
`endif

    function automatic logic [3:0][7:0] arr(input logic [7:0] a0, a1, a2, a3);
        logic [3:0][7:0] r;
        r[0] = a0;
        r[1] = a1;
        r[2] = a2;
        r[3] = a3;
        return r;
    endfunction

    function automatic vec_t mk(input logic [3:0][7:0] din, input logic [3:0] l, u,
                                input logic [3:0][7:0] dout, input logic sw,
                                input logic [3:0] cyc);
        vec_t v;
        v.din  = din;
        v.lb   = l;
        v.ub   = u;
        v.dout = dout;
        v.sw   = sw;
        v.cyc  = cyc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_chk(input string name, input logic [3:0] addr, input logic [7:0] exp);
        rd_addr = addr;
        #1;
        check($sformatf("%s rd[%0d]", name, addr), {24'd0, rd_data}, {24'd0, exp});
    endtask

    // Loads din[0..2], then loads din[3] in the same cycle as start.
    task automatic load_and_start(input logic [3:0][7:0] din, input logic [3:0] l, u);
        for (int k = 0; k < 3; k++) begin
            ld_en   = 1'b1;
            ld_addr = 4'(k);
            ld_data = din[k];
            tick();
        end
        ld_addr = 4'd3;
        ld_data = din[3];
        start   = 1'b1;
        lb      = l;
        ub      = u;
        tick();
        ld_en = 1'b0;
        start = 1'b0;
        lb    = 4'hf;
        ub    = 4'h0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int    cnt;
        string nm;
        nm = $sformatf("v%0d", idx);
        load_and_start(v.din, v.lb, v.ub);
        cnt = 0;
        while (busy && cnt < 40) begin
            cnt++;
            tick();
        end
        check({nm, " busy cycles"}, cnt, {28'd0, v.cyc});
        check({nm, " done"}, {31'd0, done}, 32'd1);
        check({nm, " swapped"}, {31'd0, swapped}, {31'd0, v.sw});
        if (v.cyc != 0) check({nm, " j"}, {28'd0, j}, {28'd0, v.ub - 4'd1});
        tick();
        check({nm, " done pulse"}, {31'd0, done}, 32'd0);
        check({nm, " swapped held"}, {31'd0, swapped}, {31'd0, v.sw});
        for (int k = 0; k < 4; k++) read_chk(nm, 4'(k), v.dout[k]);
    endtask

    initial begin
`ifdef BSORT_DESC_EN
        vecs[0] = mk(arr(5, 3, 8, 1), 0, 3, arr(5, 8, 3, 1), 1, 3);
        vecs[1] = mk(arr(1, 2, 3, 4), 0, 3, arr(2, 3, 4, 1), 1, 3);
        vecs[2] = mk(arr(1, 4, 2, 2), 0, 3, arr(4, 2, 2, 1), 1, 3);
        vecs[3] = mk(arr(4, 3, 2, 1), 1, 2, arr(4, 3, 2, 1), 0, 1);
        vecs[4] = mk(arr(7, 6, 5, 4), 3, 3, arr(7, 6, 5, 4), 0, 0);
        vecs[5] = mk(arr(2, 1, 0, 0), 0, 1, arr(2, 1, 0, 0), 0, 1);
`else
        vecs[0] = mk(arr(5, 3, 8, 1), 0, 3, arr(3, 5, 1, 8), 1, 3);
        vecs[1] = mk(arr(1, 2, 3, 4), 0, 3, arr(1, 2, 3, 4), 0, 3);
        vecs[2] = mk(arr(1, 4, 2, 2), 0, 3, arr(1, 2, 2, 4), 1, 3);
        vecs[3] = mk(arr(4, 3, 2, 1), 1, 2, arr(4, 2, 3, 1), 1, 1);
        vecs[4] = mk(arr(7, 6, 5, 4), 3, 3, arr(7, 6, 5, 4), 0, 0);
        vecs[5] = mk(arr(2, 1, 0, 0), 0, 1, arr(1, 2, 0, 0), 1, 1);
`endif

        rst     = 1'b1;
        ld_en   = 1'b0;
        start   = 1'b0;
        ld_addr = '0;
        ld_data = '0;
        lb      = '0;
        ub      = '0;
        rd_addr = '0;
        tick();
        tick();
        rst = 1'b0;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset swapped", {31'd0, swapped}, 32'd0);
        check("reset j", {28'd0, j}, 32'd0);
        for (int a = 0; a < 16; a++) read_chk("reset", 4'(a), 8'd0);

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // Mid-pass: load and restart are ignored, then reset aborts the pass.
        load_and_start(arr(9, 7, 6, 5), 4'd0, 4'd3);
        check("mid j0", {28'd0, j}, 32'd0);
        tick();
        ld_en   = 1'b1;
        ld_addr = 4'd0;
        ld_data = 8'haa;
        start   = 1'b1;
        lb      = 4'd0;
        ub      = 4'd1;
        tick();
        ld_en = 1'b0;
        start = 1'b0;
        check("mid busy", {31'd0, busy}, 32'd1);
        check("mid j2", {28'd0, j}, 32'd2);
        read_chk("mid", 4'd0, MID_RD0);
        read_chk("mid", 4'd1, MID_RD1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort done", {31'd0, done}, 32'd0);
        check("abort swapped", {31'd0, swapped}, 32'd0);
        check("abort j", {28'd0, j}, 32'd0);
        for (int a = 0; a < 4; a++) read_chk("abort", 4'(a), 8'd0);
        tick();
        tick();
        check("abort no done", {31'd0, done}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
